// File: rtl/sd_cmd_arbiter.sv
// Round-robin arbiter sharing the SD-host command register write port between
// the software register path and the data master; one command in flight at a time.
module sd_cmd_arbiter #(
  parameter int ACK_TIMEOUT = 1024,
  parameter int TO_W        = 11,
  parameter int BUSY_SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sw_req,
  input  logic [31:0] sw_arg,
  input  logic [15:0] sw_set,
  output logic        sw_ack,
  output logic        sw_err,
  input  logic        dm_req,
  input  logic [31:0] dm_arg,
  input  logic [15:0] dm_set,
  output logic        dm_ack,
  output logic        dm_err,
  output logic        cmd_we,
  output logic [31:0] cmd_arg,
  output logic [15:0] cmd_set,
  input  logic        cmd_we_ack,
  input  logic        cmd_busy,
  output logic        owner,
  output logic        arb_busy
);

  typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, WAIT_BUSY, DONE} state_t;

  localparam logic [TO_W-1:0] TO_LAST     = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [TO_W-1:0] SETTLE_LAST = TO_W'(BUSY_SETTLE - 1);

  state_t          state, state_nxt;
  logic [TO_W-1:0] cnt, cnt_nxt;
  // ptr = 1 gives the data master priority on the next contended grant
  logic            ptr, ptr_nxt;
  logic            owner_nxt, we_nxt, grant_dm;
  logic [31:0]     arg_nxt;
  logic [15:0]     set_nxt;
  logic            sw_ack_nxt, sw_err_nxt, dm_ack_nxt, dm_err_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ptr     <= 1'b1;
      owner   <= 1'b0;
      cmd_we  <= 1'b0;
      cmd_arg <= '0;
      cmd_set <= '0;
      sw_ack  <= 1'b0;
      sw_err  <= 1'b0;
      dm_ack  <= 1'b0;
      dm_err  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ptr     <= ptr_nxt;
      owner   <= owner_nxt;
      cmd_we  <= we_nxt;
      cmd_arg <= arg_nxt;
      cmd_set <= set_nxt;
      sw_ack  <= sw_ack_nxt;
      sw_err  <= sw_err_nxt;
      dm_ack  <= dm_ack_nxt;
      dm_err  <= dm_err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    ptr_nxt    = ptr;
    owner_nxt  = owner;
    we_nxt     = cmd_we;
    arg_nxt    = cmd_arg;
    set_nxt    = cmd_set;
    sw_ack_nxt = 1'b0;
    sw_err_nxt = 1'b0;
    dm_ack_nxt = 1'b0;
    dm_err_nxt = 1'b0;
    grant_dm   = dm_req && (!sw_req || ptr);
    unique case (state)
      IDLE: begin
        if (!cmd_busy && (sw_req || dm_req)) begin
          owner_nxt = grant_dm;
          arg_nxt   = grant_dm ? dm_arg : sw_arg;
          set_nxt   = grant_dm ? dm_set : sw_set;
          we_nxt    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        // an ack arriving on the final timeout cycle still completes normally
        if (cmd_we_ack) begin
          we_nxt    = 1'b0;
          cnt_nxt   = '0;
          state_nxt = SETTLE;
        end else if (cnt == TO_LAST) begin
          we_nxt     = 1'b0;
          cnt_nxt    = '0;
          sw_err_nxt = !owner;
          dm_err_nxt = owner;
          state_nxt  = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      SETTLE: begin
        // cmd_busy lags the accepted write, so it is not trusted yet
        if (cnt == SETTLE_LAST) begin
          cnt_nxt   = '0;
          state_nxt = WAIT_BUSY;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_BUSY: begin
        if (!cmd_busy) begin
          sw_ack_nxt = !owner;
          dm_ack_nxt = owner;
          state_nxt  = DONE;
        end
      end
      DONE: begin
        ptr_nxt   = !owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign arb_busy = (state != IDLE);

endmodule
